ysyx_25020047_ctrl_fsm: RTL and testbench

- Multi-cycle sequencer for the NPC core.
- Steps each instruction through fetch, decode, execute, optional memory access and writeback, around the combinational execute unit.
- Issues instruction and data memory requests with request/ack handshakes, and gates register-file and PC writes.
- Halts the core on ebreak or on an illegal instruction type.

---
 rtl/ysyx_25020047_ctrl_fsm_if.sv | 34 +++
 rtl/ysyx_25020047_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_ysyx_25020047_ctrl_fsm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_ctrl_fsm_if.sv
// Handshake bundle between the NPC sequencer and the instruction/data memories,
// register file and PC. The sequencer is the master; the memory side is the slave.
interface ysyx_25020047_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic inst_wen;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    logic rf_wen;
    logic pc_wen;

    modport master (
        output imem_req,
        input  imem_ack,
        output inst_wen,
        output dmem_req,
        output dmem_we,
        input  dmem_ack,
        output rf_wen,
        output pc_wen
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  inst_wen,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack,
        input  rf_wen,
        input  pc_wen
    );
endinterface

// File: rtl/ysyx_25020047_ctrl_fsm.sv
// Multi-cycle NPC sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, halting on ebreak/illegal.
// Optional memory-wait watchdog enabled by defining CTRL_WDT_EN (limit set by WDT_CYCLES).
module ysyx_25020047_ctrl_fsm #(
    parameter int unsigned WDT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      inst_type,
    input  logic                             exu_read,
    input  logic                             exu_write,
    input  logic                             exu_reg_wen,
    ysyx_25020047_ctrl_fsm_if.master         bus,
    output logic                             retire,
    output logic                             halt,
    output logic                             abort,
    output logic [2:0]                       state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    state_e state_r;
    state_e next_state_s;
    logic   halt_r, abort_r, halt_next_s, abort_next_s;
    logic   cap_read_r, cap_write_r, cap_wen_r;
    logic   cap_read_next_s, cap_write_next_s, cap_wen_next_s;
    logic   wdt_expired_s;
    logic   imem_req_r, dmem_req_r, dmem_we_r, rf_wen_r, pc_wen_r, retire_r;

    function automatic logic is_legal_type(input logic [31:0] t);
        case (t)
            32'h0000_0001, 32'h0000_0002, 32'h0000_0008, 32'h0000_0010,
            32'h0000_0020, 32'h0000_0040, 32'h0000_0080, 32'h0000_0160,
            32'h0000_0320: is_legal_type = 1'b1;
            default:       is_legal_type = 1'b0;
        endcase
    endfunction

    // Next-state, sticky status and EXEC-time flag capture.
    always_comb begin
        next_state_s     = state_r;
        halt_next_s      = halt_r;
        abort_next_s     = abort_r;
        cap_read_next_s  = cap_read_r;
        cap_write_next_s = cap_write_r;
        cap_wen_next_s   = cap_wen_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    next_state_s = ST_DECODE;
                end else if (wdt_expired_s) begin
                    next_state_s = ST_HALT;
                    halt_next_s  = 1'b1;
                    abort_next_s = 1'b1;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC: begin
                cap_read_next_s  = exu_read;
                cap_write_next_s = exu_write;
                cap_wen_next_s   = exu_reg_wen;
                if (inst_type == 32'h0000_0004) begin
                    next_state_s = ST_HALT;
                    halt_next_s  = 1'b1;
                    abort_next_s = 1'b0;
                end else if (!is_legal_type(inst_type)) begin
                    next_state_s = ST_HALT;
                    halt_next_s  = 1'b1;
                    abort_next_s = 1'b1;
                end else if (exu_read || exu_write) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    next_state_s = ST_WB;
                end else if (wdt_expired_s) begin
                    next_state_s = ST_HALT;
                    halt_next_s  = 1'b1;
                    abort_next_s = 1'b1;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = ST_FETCH;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_FETCH;
        endcase
    end

    // State, status, captured flags and outputs pre-decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            halt_r      <= 1'b0;
            abort_r     <= 1'b0;
            cap_read_r  <= 1'b0;
            cap_write_r <= 1'b0;
            cap_wen_r   <= 1'b0;
            imem_req_r  <= 1'b1;
            dmem_req_r  <= 1'b0;
            dmem_we_r   <= 1'b0;
            rf_wen_r    <= 1'b0;
            pc_wen_r    <= 1'b0;
            retire_r    <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            halt_r      <= halt_next_s;
            abort_r     <= abort_next_s;
            cap_read_r  <= cap_read_next_s;
            cap_write_r <= cap_write_next_s;
            cap_wen_r   <= cap_wen_next_s;
            imem_req_r  <= (next_state_s == ST_FETCH);
            // A simultaneous read+write is issued as a store.
            dmem_req_r  <= (next_state_s == ST_MEM) && (cap_read_next_s || cap_write_next_s);
            dmem_we_r   <= (next_state_s == ST_MEM) && cap_write_next_s;
            rf_wen_r    <= (next_state_s == ST_WB) && cap_wen_next_s;
            pc_wen_r    <= (next_state_s == ST_WB);
            retire_r    <= (next_state_s == ST_WB);
        end
    end

`ifdef CTRL_WDT_EN
    logic [15:0] wdt_cnt_r;

    assign wdt_expired_s = (wdt_cnt_r == 16'(WDT_CYCLES - 32'd1));

    // Wait counter: cleared on entry to FETCH/MEM, counts cycles spent staying there.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_r <= 16'd0;
        end else if (((next_state_s == ST_FETCH) || (next_state_s == ST_MEM)) &&
                     (next_state_s == state_r)) begin
            wdt_cnt_r <= wdt_cnt_r + 16'd1;
        end else begin
            wdt_cnt_r <= 16'd0;
        end
    end
`else
    logic [15:0] unused_wdt_s;
    assign unused_wdt_s  = 16'(WDT_CYCLES);
    assign wdt_expired_s = 1'b0;
`endif

    // Instruction latch follows the fetch ack in the same cycle.
    assign bus.inst_wen = (state_r == ST_FETCH) && bus.imem_ack;
    assign bus.imem_req = imem_req_r;
    assign bus.dmem_req = dmem_req_r;
    assign bus.dmem_we  = dmem_we_r;
    assign bus.rf_wen   = rf_wen_r;
    assign bus.pc_wen   = pc_wen_r;
    assign retire       = retire_r;
    assign halt         = halt_r;
    assign abort        = abort_r;
    assign state        = state_r;

endmodule

// File: tb/tb_ysyx_25020047_ctrl_fsm.sv
// Scoreboard bench for ysyx_25020047_ctrl_fsm: stimulus queues per-cycle expectations, a monitor checks them.
module tb_ysyx_25020047_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] inst_type;
    logic        exu_read, exu_write, exu_reg_wen;
    logic        retire, halt, abort;
    logic [2:0]  state;

    ysyx_25020047_ctrl_fsm_if bus_if();

    ysyx_25020047_ctrl_fsm #(.WDT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_type   (inst_type),
        .exu_read    (exu_read),
        .exu_write   (exu_write),
        .exu_reg_wen (exu_reg_wen),
        .bus         (bus_if),
        .retire      (retire),
        .halt        (halt),
        .abort       (abort),
        .state       (state)
    );

    // Layout: state[2:0], imem_req, inst_wen, dmem_req, dmem_we, rf_wen, pc_wen, retire, halt, abort
    localparam logic [11:0] F1  = 12'b000_1100000_00;
    localparam logic [11:0] F0  = 12'b000_1000000_00;
    localparam logic [11:0] DEC = 12'b001_0000000_00;
    localparam logic [11:0] EXE = 12'b010_0000000_00;
    localparam logic [11:0] MR  = 12'b011_0010000_00;
    localparam logic [11:0] MW  = 12'b011_0011000_00;
    localparam logic [11:0] WBR = 12'b100_0000111_00;
    localparam logic [11:0] WBN = 12'b100_0000011_00;
    localparam logic [11:0] HE  = 12'b101_0000000_10;
    localparam logic [11:0] HA  = 12'b101_0000000_11;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus: drive inputs just after the edge and queue the expected outputs.
    task automatic cyc(input string tag, input logic r, input logic ia, input logic da,
                       input logic [31:0] it, input logic [2:0] rww, input logic [11:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst             = r;
        bus_if.imem_ack = ia;
        bus_if.dmem_ack = da;
        inst_type       = it;
        exu_read        = rww[2];
        exu_write       = rww[1];
        exu_reg_wen     = rww[0];
        x.tag = tag;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic halt_hold(input string tag, input logic [11:0] e);
        for (int i = 0; i < 10; i++) cyc(tag, 1'b0, 1'b1, 1'b1, 32'h0, 3'b000, e);
    endtask

    // Direct status check of state, halt and abort at the next mid-cycle point.
    task automatic chk(input string tag, input logic [2:0] st, input logic h, input logic a);
        @(negedge clk);
        n_checks++;
        if ((state === st) && (halt === h) && (abort === a)) n_pass++;
        else $display("FAIL %s: got state=%0d halt=%b abort=%b, expected state=%0d halt=%b abort=%b",
                      tag, state, halt, abort, st, h, a);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation mid-cycle.
    initial begin : monitor
        logic [11:0] act;
        exp_t        x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x   = sb_q.pop_front();
                act = {state, bus_if.imem_req, bus_if.inst_wen, bus_if.dmem_req, bus_if.dmem_we,
                       bus_if.rf_wen, bus_if.pc_wen, retire, halt, abort};
                n_checks++;
                if (act === x.exp) n_pass++;
                else $display("FAIL %s: got state=%0d flags=%b, expected state=%0d flags=%b",
                              x.tag, act[11:9], act[8:0], x.exp[11:9], x.exp[8:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; bus_if.imem_ack = 1'b0; bus_if.dmem_ack = 1'b0;
        inst_type = 32'h0; exu_read = 1'b0; exu_write = 1'b0; exu_reg_wen = 1'b0;

        cyc("reset0", 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, F0);
        cyc("reset1", 1'b1, 1'b0, 1'b0, 32'h0, 3'b000, F0);
        chk("reset_state", 3'd0, 1'b0, 1'b0);

        // ALU op, acks tied high: 0,1,2,4 then back to FETCH
        cyc("alu_fetch",  1'b0, 1'b1, 1'b1, 32'h1, 3'b001, F1);
        cyc("alu_decode", 1'b0, 1'b1, 1'b1, 32'h1, 3'b001, DEC);
        cyc("alu_exec",   1'b0, 1'b1, 1'b1, 32'h1, 3'b001, EXE);
        cyc("alu_wb",     1'b0, 1'b1, 1'b1, 32'h1, 3'b001, WBR);
        cyc("alu_next",   1'b0, 1'b0, 1'b1, 32'h1, 3'b001, F0);

        // Load with dmem_ack delayed 3 cycles; stray imem_ack during MEM
        cyc("ld_fetch",  1'b0, 1'b1, 1'b0, 32'h20, 3'b101, F1);
        cyc("ld_decode", 1'b0, 1'b1, 1'b0, 32'h20, 3'b101, DEC);
        cyc("ld_exec",   1'b0, 1'b1, 1'b0, 32'h20, 3'b101, EXE);
        cyc("ld_wait1",  1'b0, 1'b1, 1'b0, 32'h20, 3'b101, MR);
        cyc("ld_wait2",  1'b0, 1'b1, 1'b0, 32'h20, 3'b101, MR);
        cyc("ld_wait3",  1'b0, 1'b1, 1'b0, 32'h20, 3'b101, MR);
        cyc("ld_ack",    1'b0, 1'b1, 1'b1, 32'h20, 3'b101, MR);
        cyc("ld_wb",     1'b0, 1'b1, 1'b0, 32'h20, 3'b101, WBR);
        cyc("ld_next",   1'b0, 1'b0, 1'b0, 32'h20, 3'b101, F0);

        // Store without register writeback
        cyc("st_fetch",  1'b0, 1'b1, 1'b1, 32'h80, 3'b010, F1);
        cyc("st_decode", 1'b0, 1'b1, 1'b1, 32'h80, 3'b010, DEC);
        cyc("st_exec",   1'b0, 1'b1, 1'b1, 32'h80, 3'b010, EXE);
        cyc("st_mem",    1'b0, 1'b1, 1'b1, 32'h80, 3'b010, MW);
        cyc("st_wb",     1'b0, 1'b1, 1'b1, 32'h80, 3'b010, WBN);
        cyc("st_next",   1'b0, 1'b0, 1'b1, 32'h80, 3'b010, F0);

        // Read and write both set: issued as a store
        cyc("rw_fetch",  1'b0, 1'b1, 1'b1, 32'h160, 3'b111, F1);
        cyc("rw_decode", 1'b0, 1'b1, 1'b1, 32'h160, 3'b111, DEC);
        cyc("rw_exec",   1'b0, 1'b1, 1'b1, 32'h160, 3'b111, EXE);
        cyc("rw_mem",    1'b0, 1'b1, 1'b1, 32'h160, 3'b111, MW);
        cyc("rw_wb",     1'b0, 1'b1, 1'b1, 32'h160, 3'b111, WBR);
        cyc("rw_next",   1'b0, 1'b0, 1'b1, 32'h160, 3'b111, F0);

        // Highest legal code, no memory, no writeback
        cyc("hi_fetch",  1'b0, 1'b1, 1'b1, 32'h320, 3'b000, F1);
        cyc("hi_decode", 1'b0, 1'b1, 1'b1, 32'h320, 3'b000, DEC);
        cyc("hi_exec",   1'b0, 1'b1, 1'b1, 32'h320, 3'b000, EXE);
        cyc("hi_wb",     1'b0, 1'b1, 1'b1, 32'h320, 3'b000, WBN);
        cyc("hi_next",   1'b0, 1'b0, 1'b1, 32'h320, 3'b000, F0);

        // ebreak beats the load request; halt holds until rst
        cyc("eb_fetch",  1'b0, 1'b1, 1'b1, 32'h4, 3'b101, F1);
        cyc("eb_decode", 1'b0, 1'b1, 1'b1, 32'h4, 3'b101, DEC);
        cyc("eb_exec",   1'b0, 1'b1, 1'b1, 32'h4, 3'b101, EXE);
        halt_hold("eb_hold", HE);
        cyc("eb_rst",    1'b1, 1'b0, 1'b0, 32'h0, 3'b000, HE);
        cyc("eb_after",  1'b0, 1'b0, 1'b0, 32'h0, 3'b000, F0);

        // Illegal type 0x0 aborts
        cyc("il_fetch",  1'b0, 1'b1, 1'b1, 32'h0, 3'b001, F1);
        cyc("il_decode", 1'b0, 1'b1, 1'b1, 32'h0, 3'b001, DEC);
        cyc("il_exec",   1'b0, 1'b1, 1'b1, 32'h0, 3'b001, EXE);
        halt_hold("il_hold", HA);
        cyc("il_rst",    1'b1, 1'b0, 1'b0, 32'h0, 3'b000, HA);
        cyc("il_after",  1'b0, 1'b0, 1'b0, 32'h0, 3'b000, F0);

        // Reset in the middle of a pending data access
        cyc("mr_fetch",  1'b0, 1'b1, 1'b0, 32'h2, 3'b100, F1);
        cyc("mr_decode", 1'b0, 1'b1, 1'b0, 32'h2, 3'b100, DEC);
        cyc("mr_exec",   1'b0, 1'b1, 1'b0, 32'h2, 3'b100, EXE);
        cyc("mr_rst",    1'b1, 1'b0, 1'b0, 32'h2, 3'b100, MR);
        cyc("mr_after",  1'b0, 1'b0, 1'b0, 32'h2, 3'b100, F0);

`ifdef CTRL_WDT_EN
        // Fetch timeout after 8 waiting cycles, then ack on the 8th cycle wins
        cyc("wdt_rst", 1'b1, 1'b0, 1'b0, 32'h1, 3'b000, F0);
        for (int i = 0; i < 8; i++) cyc("wdt_wait", 1'b0, 1'b0, 1'b0, 32'h1, 3'b000, F0);
        cyc("wdt_abort",  1'b0, 1'b0, 1'b0, 32'h1, 3'b000, HA);
        chk("wdt_expired", 3'd5, 1'b1, 1'b1);
        cyc("wdt_rst2",   1'b1, 1'b0, 1'b0, 32'h1, 3'b000, HA);
        for (int i = 0; i < 7; i++) cyc("wdt_wait2", 1'b0, 1'b0, 1'b0, 32'h1, 3'b000, F0);
        cyc("wdt_lastack", 1'b0, 1'b1, 1'b0, 32'h1, 3'b000, F1);
        cyc("wdt_decode",  1'b0, 1'b0, 1'b0, 32'h1, 3'b000, DEC);
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
